// File: rtl/btn_debounce_top.sv
// Centre push-button conditioner: two-flop synchroniser, tick-sampled debouncer,
// and a press-toggle flag, driving two LEDs (led[0] = clean level, led[1] = toggle).
module btn_debounce_top #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnC,
  output logic [1:0] led
);

  // A sub-unity quotient would leave no sampling period at all, so it is clamped to 1.
  localparam int TICK_DIV = (CLK_FREQ / TICK_HZ < 1) ? 1 : CLK_FREQ / TICK_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STB_W    = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(DEBOUNCE_TICKS - 1);

  logic             sync_meta;
  logic             sync_btn;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [STB_W-1:0] stable_cnt;
  logic             db;
  logic             db_d;
  logic             press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_btn  <= 1'b0;
    end else begin
      sync_meta <= btnC;
      sync_btn  <= sync_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // The clean level flips on the DEBOUNCE_TICKS-th consecutive differing sample;
  // any agreeing sample starts the run over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      db         <= 1'b0;
    end else if (tick) begin
      if (sync_btn == db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == STB_LAST) begin
        db         <= sync_btn;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_d <= 1'b0;
      led  <= 2'b00;
    end else begin
      db_d <= db;
      led  <= {led[1] ^ press, db};
    end
  end

endmodule

// File: tb/tb_btn_debounce_top.sv
// Self-checking bench for btn_debounce_top with a 10-clock tick and a 4-tick window:
// vector table, hand-written corner sequences and random traffic against a sample-history model.
module tb_btn_debounce_top;

  localparam int P_CLK  = 1000;
  localparam int P_TICK = 100;
  localparam int P_N    = 4;
  localparam int P_DIV  = P_CLK / P_TICK;

  logic       clk;
  logic       reset;
  logic       btnC;
  logic [1:0] led;

  int vecCount = 0;
  int errCount = 0;

  btn_debounce_top #(
    .CLK_FREQ      (P_CLK),
    .TICK_HZ       (P_TICK),
    .DEBOUNCE_TICKS(P_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btnC (btnC),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the sampled level is the button two edges back; the clean level
  // flips once the last P_N tick samples since its previous change all disagree with it.
  logic       btnHistory[$];
  logic       tickSamples[$];
  int         edgesSinceReset = 0;
  logic       mDb = 1'b0;
  int         mRises = 0;
  logic [1:0] expLed = 2'b00;

  task automatic modelClear();
    btnHistory.delete();
    btnHistory.push_back(1'b0);
    btnHistory.push_back(1'b0);
    tickSamples.delete();
    edgesSinceReset = 0;
    mDb    = 1'b0;
    mRises = 0;
    expLed = 2'b00;
  endtask

  task automatic modelStep();
    logic sample;
    bit   allDiffer;
    sample = btnHistory[1];
    btnHistory.push_front(btnC);
    void'(btnHistory.pop_back());
    edgesSinceReset++;
    expLed = {mRises[0], mDb};
    if (edgesSinceReset % P_DIV == 0) begin
      tickSamples.push_back(sample);
      if (tickSamples.size() > P_N) void'(tickSamples.pop_front());
      allDiffer = (tickSamples.size() == P_N);
      foreach (tickSamples[i]) if (tickSamples[i] == mDb) allDiffer = 1'b0;
      if (allDiffer) begin
        mDb = ~mDb;
        if (mDb) mRises++;
        tickSamples.delete();
      end
    end
  endtask

  initial begin
    modelClear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) modelClear();
      else modelStep();
    end
  end

  logic [1:0] prevLed = 2'b00;
  int l0Flips = 0;
  int l1Flips = 0;

  task automatic checkOutput(input string name, input logic [1:0] want);
    vecCount++;
    if (led !== want) begin
      errCount++;
      if (errCount <= 50)
        $display("[TB] FAIL %s: led=%b expected %b at %0t", name, led, want, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int want);
    vecCount++;
    if (actual != want) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, want, $time);
    end
  endtask

  // Each cycle: wait for the falling edge, compare against the model, track LED flips.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("model", expLed);
      if (led[0] !== prevLed[0]) l0Flips++;
      if (led[1] !== prevLed[1]) l1Flips++;
      prevLed = led;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic btn, input int cycles);
    reset = rst;
    btnC  = btn;
    if (!rst) begin
      #1;
      checkOutput("async reset", 2'b00);
    end
    stepCycles(cycles);
  endtask

  task automatic resetPulse();
    reset = 1'b0;
    #1;
    checkOutput("async reset", 2'b00);
    stepCycles(2);
    reset = 1'b1;
    prevLed = 2'b00;
    l0Flips = 0;
    l1Flips = 0;
  endtask

  typedef struct {
    logic       rst;
    logic       btn;
    int         cycles;
    logic [1:0] want;
    string      name;
  } vec_t;

  function automatic vec_t mkVec(input logic rst, input logic btn, input int cycles,
                                 input logic [1:0] want, input string name);
    vec_t v;
    v.rst = rst; v.btn = btn; v.cycles = cycles; v.want = want; v.name = name;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    vecs[0]  = mkVec(1'b1, 1'b0, 30, 2'b00, "idle low");
    vecs[1]  = mkVec(1'b1, 1'b1, 60, 2'b11, "first press");
    vecs[2]  = mkVec(1'b1, 1'b0, 60, 2'b10, "first release");
    vecs[3]  = mkVec(1'b1, 1'b1, 60, 2'b01, "second press");
    vecs[4]  = mkVec(1'b1, 1'b0, 60, 2'b00, "second release");
    vecs[5]  = mkVec(1'b1, 1'b1, 20, 2'b00, "glitch high");
    vecs[6]  = mkVec(1'b1, 1'b0, 40, 2'b00, "glitch rejected");
    vecs[7]  = mkVec(1'b1, 1'b1, 25, 2'b00, "partial press");
    vecs[8]  = mkVec(1'b0, 1'b1, 1,  2'b00, "reset mid press");
    vecs[9]  = mkVec(1'b1, 1'b1, 38, 2'b00, "held through reset early");
    vecs[10] = mkVec(1'b1, 1'b1, 5,  2'b11, "held through reset late");

    // Reset held with the button chattering: outputs stay dark.
    reset = 1'b0;
    btnC  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset hold", 2'b00);
      btnC = ~btnC;
    end
    reset = 1'b1;
    btnC  = 1'b0;
    stepCycles(50);
    checkOutput("idle after reset", 2'b00);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].btn, vecs[i].cycles);
      checkOutput(vecs[i].name, vecs[i].want);
    end

    // Bounce then hold: exactly one toggle.
    resetPulse();
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("hold early", 2'b00);
    stepCycles(23);
    checkOutput("hold recognised", 2'b11);
    stepCycles(257);
    checkOutput("hold end", 2'b11);
    checkCount("hold led1 flips", l1Flips, 1);

    // Release with single-clock chatter: one fall of led[0], led[1] untouched.
    l0Flips = 0;
    l1Flips = 0;
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, (i % 2 == 1), 1);
    applyStimulus(1'b1, 1'b0, 80);
    checkOutput("chatter release", 2'b10);
    checkCount("chatter led0 flips", l0Flips, 1);
    checkCount("chatter led1 flips", l1Flips, 0);

    // Short glitch from idle produces no press.
    resetPulse();
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 60);
    checkOutput("short glitch", 2'b00);
    checkCount("short glitch led1 flips", l1Flips, 0);

    // Random segments with occasional resets, checked every cycle against the model.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) resetPulse();
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 50));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
